tx_ep_arb: RTL

TX_EP_ARB -- requirements
Module: tx_ep_arb

---
 rtl/tx_ep_arb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tx_ep_arb.sv
// Round-robin arbiter for a shared TX endpoint: grant, tenancy, one dead cycle between tenants.
// Optional grant watchdog is enabled by defining TX_EP_ARB_WDOG_EN.
module tx_ep_arb #(
   parameter int NUM_REQ     = 4,
   parameter int WDOG_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_ep,
   input  logic [NUM_REQ-1:0]         drv_ep,
   output logic [NUM_REQ-1:0]         my_trn,
   output logic                       ep_busy,
   output logic [$clog2(NUM_REQ)-1:0] ep_owner,
   output logic                       err_drv,
   output logic                       wdog_expired
);

   localparam int                 OW       = $clog2(NUM_REQ);
   localparam logic [OW-1:0]      LAST_IDX = OW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY, GAP} state_t;

   state_t             state, state_nxt;
   logic [NUM_REQ-1:0] my_trn_nxt;
   logic               ep_busy_nxt;
   logic [OW-1:0]      ep_owner_nxt;
   logic [OW-1:0]      last_owner, last_owner_nxt;
   logic               err_drv_nxt;
   logic [OW-1:0]      winner;
   logic               found;

`ifdef TX_EP_ARB_WDOG_EN
   localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES);
   logic [15:0] wdog_cnt, wdog_cnt_nxt;
   logic        wdog_expired_nxt;
`else
   assign wdog_expired = 1'b0;
`endif

   // Rotating search: first requester after the last tenant, wrapping at NUM_REQ.
   always_comb begin
      logic [OW-1:0] cand;
      cand   = last_owner;
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (cand == LAST_IDX) ? '0 : cand + OW'(1);
         if (!found && req_ep[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // NOTE: every output of this block is defaulted first, so no path can infer a latch.
   always_comb begin
      state_nxt      = state;
      my_trn_nxt     = my_trn;
      ep_busy_nxt    = ep_busy;
      ep_owner_nxt   = ep_owner;
      last_owner_nxt = last_owner;
      err_drv_nxt    = (state == IDLE) ? |drv_ep : |(drv_ep & ~(ONE << ep_owner));
`ifdef TX_EP_ARB_WDOG_EN
      wdog_cnt_nxt     = wdog_cnt;
      wdog_expired_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               my_trn_nxt   = ONE << winner;
               ep_owner_nxt = winner;
               ep_busy_nxt  = 1'b1;
               state_nxt    = GRANT;
`ifdef TX_EP_ARB_WDOG_EN
               wdog_cnt_nxt = '0;
`endif
            end
         end
         GRANT: begin
            if (drv_ep[ep_owner]) begin
               my_trn_nxt = '0;
               state_nxt  = BUSY;
            end
`ifdef TX_EP_ARB_WDOG_EN
            else if (wdog_cnt + 16'd1 == WDOG_LIMIT) begin
               my_trn_nxt       = '0;
               ep_busy_nxt      = 1'b0;
               wdog_expired_nxt = 1'b1;
               last_owner_nxt   = ep_owner;
               state_nxt        = GAP;
            end else begin
               wdog_cnt_nxt = wdog_cnt + 16'd1;
            end
`endif
         end
         BUSY: begin
            if (!drv_ep[ep_owner]) begin
               ep_busy_nxt    = 1'b0;
               last_owner_nxt = ep_owner;
               state_nxt      = GAP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         my_trn     <= '0;
         ep_busy    <= 1'b0;
         ep_owner   <= '0;
         last_owner <= LAST_IDX;
         err_drv    <= 1'b0;
      end else begin
         state      <= state_nxt;
         my_trn     <= my_trn_nxt;
         ep_busy    <= ep_busy_nxt;
         ep_owner   <= ep_owner_nxt;
         last_owner <= last_owner_nxt;
         err_drv    <= err_drv_nxt;
      end
   end

`ifdef TX_EP_ARB_WDOG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt     <= '0;
         wdog_expired <= 1'b0;
      end else begin
         wdog_cnt     <= wdog_cnt_nxt;
         wdog_expired <= wdog_expired_nxt;
      end
   end
`endif

endmodule
